// File: rtl/mem_sequencer.sv
// Sequences decoded core memory ops and stream (DMA) traffic onto one req/ack memory port.
// Core reads complete 1 cycle after mem_ack; core_ready drops while a read is pending or the write buffer is full.
module mem_sequencer #(
    parameter int MAIN_ADDR_WIDTH = 16,
    parameter int WORD_WIDTH      = 32,
    parameter int NUM_DCS         = 4,
    parameter int WBUF_DEPTH      = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 core_valid,
    input  logic [2:0]                           core_op,
    input  logic [$clog2(NUM_DCS)-1:0]           core_dc_sel,
    input  logic [MAIN_ADDR_WIDTH-1:0]           core_addr,
    input  logic [WORD_WIDTH-1:0]                core_wdata,
    output logic                                 core_ready,
    output logic [NUM_DCS*MAIN_ADDR_WIDTH-1:0]   dcs,
    input  logic                                 stream_in_valid,
    input  logic                                 stream_out_valid,
    input  logic [MAIN_ADDR_WIDTH-1:0]           stream_address,
    input  logic [WORD_WIDTH-1:0]                stream_in_value,
    output logic                                 stream_done,
    output logic                                 mem_req,
    output logic                                 mem_we,
    output logic [MAIN_ADDR_WIDTH-1:0]           mem_addr,
    output logic [WORD_WIDTH-1:0]                mem_wdata,
    input  logic                                 mem_ack,
    input  logic [WORD_WIDTH-1:0]                mem_rdata,
    output logic                                 rdata_valid,
    output logic [WORD_WIDTH-1:0]                rdata,
    output logic [1:0]                           rdata_dest
);
    localparam int AW  = MAIN_ADDR_WIDTH;
    localparam int WW  = WORD_WIDTH;
    localparam int PW  = $clog2(WBUF_DEPTH);
    localparam int SCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_RD = 2'd1;
    localparam logic [1:0] BUSY_WR = 2'd2;

    localparam logic [1:0] SRC_CORE_RD = 2'd0;
    localparam logic [1:0] SRC_WBUF    = 2'd1;
    localparam logic [1:0] SRC_S_IN    = 2'd2;
    localparam logic [1:0] SRC_S_OUT   = 2'd3;

    localparam logic [2:0] OP_READ_CONV   = 3'd0;
    localparam logic [2:0] OP_READ_DSTACK = 3'd1;
    localparam logic [2:0] OP_READ_RELOAD = 3'd2;
    localparam logic [2:0] OP_WRITE       = 3'd3;
    localparam logic [2:0] OP_WRITE_POST  = 3'd4;
    localparam logic [2:0] OP_SET_DC      = 3'd5;

    logic [AW-1:0]         dcs_q [NUM_DCS];
    logic [AW-1:0]         dcs_d [NUM_DCS];
    logic [AW-1:0]         wb_addr_q [WBUF_DEPTH];
    logic [AW-1:0]         wb_addr_d [WBUF_DEPTH];
    logic [WW-1:0]         wb_data_q [WBUF_DEPTH];
    logic [WW-1:0]         wb_data_d [WBUF_DEPTH];
    logic [WBUF_DEPTH-1:0] wb_vld_q, wb_vld_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  rd_pending_q, rd_pending_d;
    logic [AW-1:0]         rd_addr_q, rd_addr_d;
    logic [1:0]            rd_dest_q, rd_dest_d;
    logic [SCW-1:0]        starve_q, starve_d;
    logic [1:0]            state_q, state_d, src_q, src_d;
    logic                  first_q, first_d;
    logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [AW-1:0]         mem_addr_q, mem_addr_d;
    logic [WW-1:0]         mem_wdata_q, mem_wdata_d;
    logic                  rdata_valid_q, rdata_valid_d, stream_done_q, stream_done_d;
    logic [WW-1:0]         rdata_q, rdata_d;
    logic [1:0]            rdata_dest_q, rdata_dest_d;

    logic          rd_hit, core_accept, s_in, s_out, s_any, ack_ok;
    logic          enq, deq, iss, iss_we;
    logic [AW-1:0] enq_addr, iss_addr;
    logic [WW-1:0] enq_data, iss_wdata;
    logic [1:0]    iss_src;

    assign core_ready  = !rd_pending_q && !(&wb_vld_q);
    assign core_accept = core_valid && core_ready;
    // The source only drops its request after seeing stream_done, so mask it for that cycle.
    assign s_in   = stream_in_valid && !stream_done_q;
    assign s_out  = stream_out_valid && !stream_done_q;
    assign s_any  = s_in || s_out;
    assign ack_ok = (state_q != IDLE) && !first_q && mem_ack;

    always_comb begin
        rd_hit = 1'b0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (wb_vld_q[i] && (wb_addr_q[i] == rd_addr_q)) rd_hit = 1'b1;
        end
    end

    always_comb begin
        dcs_d = dcs_q;  wb_addr_d = wb_addr_q;  wb_data_d = wb_data_q;  wb_vld_d = wb_vld_q;
        wr_ptr_d = wr_ptr_q;  rd_ptr_d = rd_ptr_q;
        rd_pending_d = rd_pending_q;  rd_addr_d = rd_addr_q;  rd_dest_d = rd_dest_q;
        starve_d = starve_q;  state_d = state_q;  src_d = src_q;  first_d = 1'b0;
        mem_req_d = mem_req_q;  mem_we_d = mem_we_q;  mem_addr_d = mem_addr_q;  mem_wdata_d = mem_wdata_q;
        rdata_valid_d = 1'b0;  rdata_d = rdata_q;  rdata_dest_d = rdata_dest_q;  stream_done_d = 1'b0;
        enq = 1'b0;  enq_addr = '0;  enq_data = '0;  deq = 1'b0;
        iss = 1'b0;  iss_we = 1'b0;  iss_addr = '0;  iss_wdata = '0;  iss_src = SRC_CORE_RD;

        if (core_accept) begin
            case (core_op)
                OP_READ_CONV:   begin rd_pending_d = 1'b1; rd_addr_d = core_addr; rd_dest_d = 2'd0; end
                OP_READ_DSTACK: begin rd_pending_d = 1'b1; rd_addr_d = core_addr; rd_dest_d = 2'd1; end
                OP_READ_RELOAD: begin
                    dcs_d[core_dc_sel] = core_addr;
                    rd_pending_d = 1'b1; rd_addr_d = core_addr; rd_dest_d = 2'd2;
                end
                OP_WRITE:       begin enq = 1'b1; enq_addr = core_addr; enq_data = core_wdata; end
                OP_WRITE_POST:  begin
                    dcs_d[core_dc_sel] = core_addr;
                    enq = 1'b1; enq_addr = dcs_q[core_dc_sel]; enq_data = core_wdata;
                    rd_pending_d = 1'b1; rd_addr_d = core_addr; rd_dest_d = 2'd2;
                end
                OP_SET_DC:      dcs_d[core_dc_sel] = core_addr;
                default: ;
            endcase
        end

        if (ack_ok) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            state_d   = IDLE;
            case (src_q)
                SRC_CORE_RD: begin
                    rdata_valid_d = 1'b1; rdata_d = mem_rdata; rdata_dest_d = rd_dest_q;
                    rd_pending_d = 1'b0;
                end
                SRC_WBUF:  deq = 1'b1;
                SRC_S_IN:  stream_done_d = 1'b1;
                default: begin
                    stream_done_d = 1'b1;
                    rdata_valid_d = 1'b1; rdata_d = mem_rdata; rdata_dest_d = 2'd3;
                end
            endcase
        end else if (state_q == IDLE) begin
            if (s_any && (starve_q == STARVE_MAX)) begin
                iss = 1'b1; iss_we = s_in; iss_addr = stream_address; iss_wdata = stream_in_value;
                iss_src = s_in ? SRC_S_IN : SRC_S_OUT;
                starve_d = '0;
            end else if (rd_pending_q && !rd_hit) begin
                iss = 1'b1; iss_addr = rd_addr_q; iss_src = SRC_CORE_RD;
                if (s_any) starve_d = starve_q + 1'b1;
            end else if (wb_vld_q[rd_ptr_q]) begin
                iss = 1'b1; iss_we = 1'b1; iss_src = SRC_WBUF;
                iss_addr = wb_addr_q[rd_ptr_q]; iss_wdata = wb_data_q[rd_ptr_q];
                if (s_any) starve_d = starve_q + 1'b1;
            end else if (s_any) begin
                iss = 1'b1; iss_we = s_in; iss_addr = stream_address; iss_wdata = stream_in_value;
                iss_src = s_in ? SRC_S_IN : SRC_S_OUT;
                starve_d = '0;
            end
        end

        if (iss) begin
            mem_req_d = 1'b1;  mem_we_d = iss_we;  mem_addr_d = iss_addr;  mem_wdata_d = iss_wdata;
            state_d = iss_we ? BUSY_WR : BUSY_RD;
            src_d   = iss_src;
            first_d = 1'b1;
        end

        // Head entry stays valid until its write is acked so pending reads keep seeing it.
        if (deq) begin
            wb_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (enq) begin
            wb_vld_d[wr_ptr_q]  = 1'b1;
            wb_addr_d[wr_ptr_q] = enq_addr;
            wb_data_d[wr_ptr_q] = enq_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DCS; i++) dcs_q[i] <= '0;
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                wb_addr_q[i] <= '0;
                wb_data_q[i] <= '0;
            end
            wb_vld_q <= '0;  wr_ptr_q <= '0;  rd_ptr_q <= '0;
            rd_pending_q <= 1'b0;  rd_addr_q <= '0;  rd_dest_q <= '0;
            starve_q <= '0;  state_q <= IDLE;  src_q <= SRC_CORE_RD;  first_q <= 1'b0;
            mem_req_q <= 1'b0;  mem_we_q <= 1'b0;  mem_addr_q <= '0;  mem_wdata_q <= '0;
            rdata_valid_q <= 1'b0;  rdata_q <= '0;  rdata_dest_q <= '0;  stream_done_q <= 1'b0;
        end else begin
            dcs_q <= dcs_d;  wb_addr_q <= wb_addr_d;  wb_data_q <= wb_data_d;  wb_vld_q <= wb_vld_d;
            wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;
            rd_pending_q <= rd_pending_d;  rd_addr_q <= rd_addr_d;  rd_dest_q <= rd_dest_d;
            starve_q <= starve_d;  state_q <= state_d;  src_q <= src_d;  first_q <= first_d;
            mem_req_q <= mem_req_d;  mem_we_q <= mem_we_d;  mem_addr_q <= mem_addr_d;  mem_wdata_q <= mem_wdata_d;
            rdata_valid_q <= rdata_valid_d;  rdata_q <= rdata_d;  rdata_dest_q <= rdata_dest_d;
            stream_done_q <= stream_done_d;
        end
    end

    for (genvar g = 0; g < NUM_DCS; g++) begin : g_dcs
        assign dcs[g*AW +: AW] = dcs_q[g];
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata       = rdata_q;
    assign rdata_dest  = rdata_dest_q;
    assign stream_done = stream_done_q;
endmodule

// File: doc/mem_sequencer.md
Name: mem_sequencer

Overview:
Clocked successor to the combinational memory-control decoder. It owns the NUM_DCS data-counter registers and accepts decoded core memory operations over a valid/ready handshake. It posts core writes into a WBUF_DEPTH write buffer, arbitrates core and stream (DMA) traffic with a starvation guard, and drives a single variable-latency req/ack main-memory port. It sits between the core decode stage and the main memory, and returns read data tagged with its destination (conveyor, dstack, DC reload, stream).

Parameters:
MAIN_ADDR_WIDTH, 16, main memory address width
WORD_WIDTH, 32, data word width
NUM_DCS, 4, number of data-counter registers (>=2)
WBUF_DEPTH, 4, posted-write buffer entries (power of 2, >=2)
STARVE_LIMIT, 8, max consecutive core issues while a stream request waits (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
core_valid  in  1  core operation present
core_op  in  3  0 READ_CONV, 1 READ_DSTACK, 2 READ_RELOAD, 3 WRITE, 4 WRITE_POST, 5 SET_DC, 6-7 reserved
core_dc_sel  in  $clog2(NUM_DCS)  DC index
core_addr  in  MAIN_ADDR_WIDTH  operation address / new DC value
core_wdata  in  WORD_WIDTH  write data
core_ready  out  1  operation accepted when core_valid&&core_ready
dcs  out  NUM_DCS*MAIN_ADDR_WIDTH  DC registers, dcs[i] at bits [i*MAIN_ADDR_WIDTH +: MAIN_ADDR_WIDTH]
stream_in_valid  in  1  stream write request (held until stream_done)
stream_out_valid  in  1  stream read request (held until stream_done)
stream_address  in  MAIN_ADDR_WIDTH  stream address
stream_in_value  in  WORD_WIDTH  stream write data
stream_done  out  1  one-cycle pulse, stream transfer complete
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  MAIN_ADDR_WIDTH  memory address
mem_wdata  out  WORD_WIDTH  memory write data
mem_ack  in  1  transfer complete this cycle
mem_rdata  in  WORD_WIDTH  read data, valid with mem_ack
rdata_valid  out  1  one-cycle read-result pulse
rdata  out  WORD_WIDTH  registered read data
rdata_dest  out  2  0 conveyor, 1 dstack, 2 DC reload, 3 stream

Behaviour:
- Clock is clk. Reset is synchronous and active-high. On reset: all dcs=0, buffer empty, rd_pending=0, starve count=0, FSM=IDLE. Also mem_req=0, mem_we=0, stream_done=0, rdata_valid=0, rdata_dest=0, rdata=0. core_ready is 1 in the first cycle after reset.
- Reset mid-transfer abandons the transfer. mem_req drops the next cycle and no rdata_valid or stream_done follows. The memory tolerates abandoned requests.
- core_ready = !rd_pending && !wbuf_full. It depends only on registered state.
- DC updates in the accept cycle:
  - READ_RELOAD, WRITE_POST and SET_DC load dcs[sel] <= core_addr.
  - WRITE_POST enqueues the write {addr = old dcs[sel], data = core_wdata}.
- Enqueue and read registration in the accept cycle:
  - WRITE enqueues {core_addr, core_wdata}.
  - READ_CONV, READ_DSTACK, READ_RELOAD and WRITE_POST register a pending read of core_addr, with dest 0, 1, 2 and 2 respectively.
  - Reserved ops are accepted with no effect.
  - Enqueue and dequeue in the same cycle are both performed.
- FSM states are IDLE, BUSY_RD and BUSY_WR. In IDLE, one transfer is issued per cycle by priority:
  1. A stream request, if starve count == STARVE_LIMIT.
  2. The pending core read, if its address matches no buffer entry.
  3. The buffer head write.
  4. stream_in.
  5. stream_out.
- A pending read whose address hits the buffer waits until every matching entry has drained. This guarantees read-after-write ordering.
- Starve count increments on each core issue (read or buffer write) while any stream request is pending and not yet issued. It clears on any stream issue.
- Issue cycle: mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until the cycle mem_ack is sampled high. mem_ack is ignored in IDLE and in the issue cycle itself (minimum latency is 2 cycles from issue to ack). The cycle after ack: mem_req=0, FSM=IDLE, and the next issue can occur in that same cycle.
- Read completion: the cycle after mem_ack, rdata_valid=1 with rdata=mem_rdata and rdata_dest set. rd_pending clears then.
- Stream completion: stream_done pulses the cycle after mem_ack. For stream_out it coincides with rdata_valid and rdata_dest=3.
- Simultaneous stream_in and stream_out: stream_in wins; stream_out is served afterwards.
- Buffer full: core_ready=0 until an entry drains. Pointers wrap modulo WBUF_DEPTH.

Test Plan:
- Reset, then core WRITE addr 0x10 data 0xAA, then READ_CONV 0x10 -> write issued before read; rdata_valid with rdata=0xAA, dest=0; mem_req never overlaps.
- WRITE_POST sel=1 with dcs[1]=0x20, core_addr=0x24, wdata=5 -> dcs[1]=0x24 in accept cycle; memory write @0x20=5; read @0x24 returns dest=2.
- Five back-to-back WRITEs, WBUF_DEPTH=4, mem_ack latency 3 -> core_ready low after the 4th accept, high the cycle after the first ack; all 5 written in order.
- stream_out pending with a continuous core write stream, STARVE_LIMIT=2 -> stream issued after exactly 2 core issues; stream_done and rdata_valid dest=3 together.
- stream_in and stream_out asserted together, no core traffic -> stream_in write first, then stream_out read; one stream_done per transfer.
- Reset asserted while mem_req high awaiting ack -> mem_req=0 and dcs=0 next cycle; late mem_ack produces no rdata_valid.
